// File: rtl/alu_issue_ctrl.sv
//==============================================================================
// alu_issue_ctrl : issues 8-bit commands to an external combinational ALU,
//                  sequencing multi-pass shifts and holding responses. Rev 1.0
//==============================================================================
`default_nettype none

module alu_issue_ctrl (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic [3:0] cmd_op_i,
   input  logic [7:0] cmd_a_i,
   input  logic [7:0] cmd_b_i,
   output logic [7:0] alu_a_o,
   output logic [7:0] alu_b_o,
   output logic [2:0] alu_cont_o,
   input  logic [7:0] alu_result_i,
   input  logic       alu_z_i,
   input  logic       alu_n_i,
   input  logic       alu_c_i,
   input  logic       alu_o_i,
   output logic       rsp_valid_o,
   input  logic       rsp_ready_i,
   output logic [7:0] rsp_result_o,
   output logic [3:0] rsp_flags_o,
   output logic       rsp_err_o,
   output logic [3:0] stat_flags_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_ITER = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   localparam logic [2:0] C_MOV = 3'b001;

   logic [1:0] state_q,      state_d;
   logic [7:0] alu_a_q,      alu_a_d;
   logic [7:0] alu_b_q,      alu_b_d;
   logic [2:0] alu_cont_q,   alu_cont_d;
   logic [2:0] cnt_q,        cnt_d;
   logic       use_a_q,      use_a_d;
   logic [7:0] rsp_result_q, rsp_result_d;
   logic [3:0] rsp_flags_q,  rsp_flags_d;
   logic       rsp_err_q,    rsp_err_d;
   logic [3:0] stat_flags_q, stat_flags_d;

   logic       dec_legal;
   logic [2:0] dec_cont;
   logic [2:0] dec_cnt;
   logic       dec_use_a;
   logic [3:0] alu_flags;
   logic [2:0] shift_k;

   assign shift_k   = cmd_b_i[2:0];
   assign alu_flags = {alu_z_i, alu_n_i, alu_c_i, alu_o_i};

   // Shift count of zero degenerates to a single MOV pass that returns operand A.
   always_comb begin
      dec_legal = 1'b1;
      dec_cont  = C_MOV;
      dec_cnt   = 3'd0;
      dec_use_a = 1'b0;
      case (cmd_op_i)
         4'b0000: dec_cont = 3'b000;
         4'b0001: dec_cont = 3'b001;
         4'b0010: dec_cont = 3'b010;
         4'b0011: dec_cont = 3'b011;
         4'b0100: dec_cont = 3'b100;
         4'b0101: dec_cont = 3'b101;
         4'b0111: dec_cont = 3'b111;
         4'b1000: begin
            dec_cont  = (shift_k == 3'd0) ? C_MOV : 3'b111;
            dec_cnt   = shift_k;
            dec_use_a = (shift_k == 3'd0);
         end
         4'b1001: begin
            dec_cont  = (shift_k == 3'd0) ? C_MOV : 3'b011;
            dec_cnt   = shift_k;
            dec_use_a = (shift_k == 3'd0);
         end
         4'b1010: begin
            dec_cont  = 3'b010;
            dec_use_a = 1'b1;
         end
         default: dec_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_cont_d   = alu_cont_q;
      cnt_d        = cnt_q;
      use_a_d      = use_a_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
      rsp_err_d    = rsp_err_q;
      stat_flags_d = stat_flags_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid_i) begin
               alu_a_d    = cmd_a_i;
               alu_b_d    = cmd_b_i;
               alu_cont_d = dec_cont;
               cnt_d      = dec_cnt;
               use_a_d    = dec_use_a;
               if (dec_legal) begin
                  state_d = S_EXEC;
               end else begin
                  state_d      = S_RESP;
                  rsp_err_d    = 1'b1;
                  rsp_result_d = 8'h00;
                  rsp_flags_d  = 4'b0000;
               end
            end
         end
         S_EXEC, S_ITER: begin
            // cnt_q counts passes still to run including the current one.
            if (cnt_q > 3'd1) begin
               state_d = S_ITER;
               cnt_d   = cnt_q - 3'd1;
               alu_a_d = alu_result_i;
            end else begin
               state_d      = S_RESP;
               cnt_d        = 3'd0;
               rsp_result_d = use_a_q ? alu_a_q : alu_result_i;
               rsp_flags_d  = alu_flags;
               rsp_err_d    = 1'b0;
               stat_flags_d = alu_flags;
            end
         end
         S_RESP: begin
            if (rsp_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         alu_a_q      <= 8'h00;
         alu_b_q      <= 8'h00;
         alu_cont_q   <= C_MOV;
         cnt_q        <= 3'd0;
         use_a_q      <= 1'b0;
         rsp_result_q <= 8'h00;
         rsp_flags_q  <= 4'b0000;
         rsp_err_q    <= 1'b0;
         stat_flags_q <= 4'b0000;
      end else begin
         state_q      <= state_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_cont_q   <= alu_cont_d;
         cnt_q        <= cnt_d;
         use_a_q      <= use_a_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
         rsp_err_q    <= rsp_err_d;
         stat_flags_q <= stat_flags_d;
      end
   end

   assign cmd_ready_o  = (state_q == S_IDLE);
   assign rsp_valid_o  = (state_q == S_RESP);
   assign alu_a_o      = alu_a_q;
   assign alu_b_o      = alu_b_q;
   assign alu_cont_o   = alu_cont_q;
   assign rsp_result_o = rsp_result_q;
   assign rsp_flags_o  = rsp_flags_q;
   assign rsp_err_o    = rsp_err_q;
   assign stat_flags_o = stat_flags_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
//==============================================================================
// tb_alu_issue_ctrl : directed and random checks of alu_issue_ctrl against a
//                     behavioural model of the command set. Rev 1.0
//==============================================================================
`default_nettype none

module tb_alu_issue_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_op = 4'd0;
   logic [7:0] cmd_a = 8'd0;
   logic [7:0] cmd_b = 8'd0;
   logic [7:0] alu_a, alu_b;
   logic [2:0] alu_cont;
   logic [7:0] alu_result;
   logic       alu_z, alu_n, alu_c, alu_o;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_result;
   logic [3:0] rsp_flags;
   logic       rsp_err;
   logic [3:0] stat_flags;

   int n_checks = 0;
   int n_errors = 0;
   logic [3:0] exp_stat = 4'b0000;

   always #5 clk = ~clk;

   alu_issue_ctrl dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .cmd_valid_i  (cmd_valid),
      .cmd_ready_o  (cmd_ready),
      .cmd_op_i     (cmd_op),
      .cmd_a_i      (cmd_a),
      .cmd_b_i      (cmd_b),
      .alu_a_o      (alu_a),
      .alu_b_o      (alu_b),
      .alu_cont_o   (alu_cont),
      .alu_result_i (alu_result),
      .alu_z_i      (alu_z),
      .alu_n_i      (alu_n),
      .alu_c_i      (alu_c),
      .alu_o_i      (alu_o),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_result_o (rsp_result),
      .rsp_flags_o  (rsp_flags),
      .rsp_err_o    (rsp_err),
      .stat_flags_o (stat_flags)
   );

   // Combinational ALU: carry is the bit shifted out for shifts, borrow for SUB.
   logic [8:0] alu_w;
   always_comb begin
      alu_w  = 9'd0;
      alu_c  = 1'b0;
      alu_o  = 1'b0;
      case (alu_cont)
         3'b000: begin
            alu_w = {1'b0, alu_a} + {1'b0, alu_b};
            alu_c = alu_w[8];
            alu_o = (alu_a[7] == alu_b[7]) && (alu_w[7] != alu_a[7]);
         end
         3'b001: alu_w = {1'b0, alu_a};
         3'b010: begin
            alu_w = {1'b0, alu_a} - {1'b0, alu_b};
            alu_c = alu_w[8];
            alu_o = (alu_a[7] != alu_b[7]) && (alu_w[7] != alu_a[7]);
         end
         3'b011: begin alu_w = {2'b00, alu_a[7:1]}; alu_c = alu_a[0]; end
         3'b100: alu_w = {1'b0, alu_a & alu_b};
         3'b101: alu_w = {1'b0, alu_a | alu_b};
         3'b111: begin alu_w = {1'b0, alu_a[6:0], 1'b0}; alu_c = alu_a[7]; end
         default: alu_w = 9'd0;
      endcase
      alu_result = alu_w[7:0];
      alu_z = (alu_w[7:0] == 8'd0);
      alu_n = alu_w[7];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: whole-command outcome computed directly from the command rules.
   task automatic ref_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] r, output logic [3:0] f,
                         output logic e, output int lat);
      int k, s, u;
      logic [7:0] v;
      logic c, o;
      k = int'(b[2:0]);
      e = 1'b0; c = 1'b0; o = 1'b0; lat = 2; v = 8'd0;
      case (op)
         4'd0: begin
            u = int'(a) + int'(b); v = u[7:0]; c = (u > 255);
            s = int'($signed(a)) + int'($signed(b)); o = (s > 127) || (s < -128);
         end
         4'd1: v = a;
         4'd2, 4'd10: begin
            u = int'(a) - int'(b); v = u[7:0]; c = (a < b);
            s = int'($signed(a)) - int'($signed(b)); o = (s > 127) || (s < -128);
         end
         4'd3: begin v = a / 8'd2; c = a[0]; end
         4'd4: v = a & b;
         4'd5: v = a | b;
         4'd7: begin u = int'(a) * 2; v = u[7:0]; c = a[7]; end
         4'd8: begin
            if (k == 0) v = a;
            else begin u = int'(a) << k; v = u[7:0]; c = u[8]; lat = k + 1; end
         end
         4'd9: begin
            if (k == 0) v = a;
            else begin v = a >> k; c = a[k-1]; lat = k + 1; end
         end
         default: begin e = 1'b1; lat = 1; end
      endcase
      r = (op == 4'd10) ? a : v;
      f = e ? 4'b0000 : {(v == 8'd0), v[7], c, o};
      if (e) r = 8'h00;
   endtask

   task automatic do_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int hold);
      logic [7:0] er;
      logic [3:0] ef;
      logic       ee;
      int         el, edges;
      ref_op(op, a, b, er, ef, ee, el);
      if (!ee) exp_stat = ef;
      @(negedge clk);
      check("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
      rsp_ready = (hold == 0);
      @(posedge clk); @(negedge clk);
      cmd_valid = 1'b0; cmd_op = 4'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
      edges = 1;
      while (!rsp_valid && edges < 20) begin
         @(posedge clk); @(negedge clk);
         edges++;
      end
      check("latency", edges, el);
      check("rsp_result", rsp_result, er);
      check("rsp_flags", rsp_flags, ef);
      check("rsp_err", rsp_err, ee);
      check("stat_flags", stat_flags, exp_stat);
      check("cmd_ready_busy", cmd_ready, 0);
      if (ee) check("alu_cont_illegal", alu_cont, 3'b001);
      for (int i = 0; i < hold; i++) begin
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_op = 4'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
         @(posedge clk); @(negedge clk);
         check("hold_valid", rsp_valid, 1);
         check("hold_result", rsp_result, er);
         check("hold_flags", rsp_flags, ef);
         check("hold_ready", cmd_ready, 0);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_drop", rsp_valid, 0);
      check("cmd_ready_back", cmd_ready, 1);
   endtask

   initial begin
      int prev, accepts, waitc;
      // Reset state.
      rst_n = 1'b0;
      @(posedge clk); @(posedge clk); @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_rsp_result", rsp_result, 8'h00);
      check("rst_rsp_flags", rsp_flags, 4'h0);
      check("rst_stat", stat_flags, 4'h0);
      check("rst_alu_a", alu_a, 8'h00);
      check("rst_alu_b", alu_b, 8'h00);
      check("rst_alu_cont", alu_cont, 3'b001);
      rst_n = 1'b1;

      // Directed: ADD overflow, CMP equal, illegal, long shifts, backpressure.
      do_cmd(4'b0000, 8'h7F, 8'h01, 0);
      check("add_stat_0101", stat_flags, 4'b0101);
      do_cmd(4'b1010, 8'h05, 8'h05, 0);
      check("cmp_stat_z", stat_flags[3], 1);
      do_cmd(4'b0110, 8'h12, 8'h34, 0);
      check("illegal_stat_kept", stat_flags, 4'b1000);
      do_cmd(4'b1000, 8'h01, 8'h07, 0);
      do_cmd(4'b1001, 8'h80, 8'h00, 0);
      do_cmd(4'b0101, 8'hF0, 8'h0F, 5);
      do_cmd(4'b1001, 8'hB5, 8'h03, 1);
      do_cmd(4'b1000, 8'hB5, 8'h01, 0);

      // Reset during ITER of SHLN k=5 discards the operation.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 4'b1000; cmd_a = 8'h01; cmd_b = 8'h05;
      @(posedge clk); @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check("midop_no_rsp", rsp_valid, 0);
         @(posedge clk); @(negedge clk);
      end
      rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      check("midrst_ready", cmd_ready, 1);
      check("midrst_rsp_valid", rsp_valid, 0);
      check("midrst_stat", stat_flags, 4'h0);
      check("midrst_alu_cont", alu_cont, 3'b001);
      rst_n = 1'b1;
      exp_stat = 4'h0;
      do_cmd(4'b0000, 8'h10, 8'h20, 0);

      // Back-to-back: one accept every 3 cycles.
      @(negedge clk);
      rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_op = 4'b0000; cmd_a = 8'hC0; cmd_b = 8'h40;
      prev = -1; accepts = 0;
      for (int cyc = 0; cyc < 15; cyc++) begin
         if (cmd_ready) begin
            if (prev >= 0) check("b2b_gap", cyc - prev, 3);
            prev = cyc; accepts++;
         end
         @(posedge clk); @(negedge clk);
      end
      cmd_valid = 1'b0;
      check("b2b_accepts", accepts, 5);
      waitc = 0;
      while (!cmd_ready && waitc < 10) begin
         @(posedge clk); @(negedge clk);
         waitc++;
      end
      rsp_ready = 1'b0;
      exp_stat = 4'b1010;
      check("b2b_stat", stat_flags, exp_stat);

      // Random commands with random backpressure.
      for (int n = 0; n < 60; n++) begin
         do_cmd(4'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
